// File: rtl/nand_share_arbiter_pkg.sv
// nand_share_arbiter_pkg: shared state encodings and op codes for the NAND share arbiter
package nand_share_arbiter_pkg;
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EVAL = 2'd1,
        ST_ACK  = 2'd2
    } state_t;
    localparam logic OP_NAND = 1'b0;
    localparam logic OP_AND  = 1'b1;
endpackage

// File: rtl/nand_share_arbiter_nand_gate.sv
// NAND_GATE: the single shared two-input NAND primitive
//   a, b : operands
//   y    : ~(a & b)
module NAND_GATE (
    input  logic a,
    input  logic b,
    output logic y
);
    assign y = ~(a & b);
endmodule

// File: rtl/nand_share_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker, first set req at or above ptr, with wrap
//   req : request vector
//   ptr : search start index
//   any : at least one request present
//   idx : index of the winner (0 when any is low)
module rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    output logic               any,
    output logic [ID_W-1:0]    idx
);
    logic [NUM_REQ-1:0]   mask;
    logic [2*NUM_REQ-1:0] dbl;
    // The lower half holds requests at or above ptr; the upper half is the full
    // vector, so the lowest set bit of dbl is the wrapped round-robin winner.
    always_comb begin
        mask = ~((NUM_REQ'(1) << ptr) - NUM_REQ'(1));
        dbl  = {req, req & mask};
        any  = |req;
        idx  = '0;
        for (int i = 2*NUM_REQ-1; i >= 0; i--)
            if (dbl[i]) idx = ID_W'(i % NUM_REQ);
    end
endmodule

// File: rtl/nand_share_arbiter.sv
// nand_share_arbiter: round-robin sharing of one NAND gate among NUM_REQ requesters
//   clk, rst : clock, synchronous active-high reset
//   req      : per-requester level request, held until ack
//   in0, in1 : per-requester operand bits
//   op       : per-requester op select (0 NAND, 1 AND)
//   ack      : one-cycle one-hot completion pulse
//   out      : result of the granted op, held between ops
//   busy     : high while an op is in flight
//   gnt_id   : index of the current or last granted requester
module nand_share_arbiter
    import nand_share_arbiter_pkg::*;
#(
    parameter  int NUM_REQ = 4,
    localparam int ID_W    = $clog2(NUM_REQ)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    input  logic [NUM_REQ-1:0] in0,
    input  logic [NUM_REQ-1:0] in1,
    input  logic [NUM_REQ-1:0] op,
    output logic [NUM_REQ-1:0] ack,
    output logic               out,
    output logic               busy,
    output logic [ID_W-1:0]    gnt_id
);
    state_t             state, state_nxt;
    logic               a, b, o, a_nxt, b_nxt, o_nxt;
    logic [ID_W-1:0]    rr_ptr, rr_ptr_nxt, gnt_nxt, pick_idx;
    logic               pick_any, nand_y, out_nxt;
    logic [NUM_REQ-1:0] ack_nxt;

    rr_pick #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_pick (
        .req (req),
        .ptr (rr_ptr),
        .any (pick_any),
        .idx (pick_idx)
    );

    NAND_GATE u_nand (
        .a (a),
        .b (b),
        .y (nand_y)
    );

    assign busy = (state != ST_IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= ST_IDLE;
            ack    <= '0;
            out    <= 1'b0;
            gnt_id <= '0;
            rr_ptr <= '0;
            a      <= 1'b0;
            b      <= 1'b0;
            o      <= OP_NAND;
        end else begin
            state  <= state_nxt;
            ack    <= ack_nxt;
            out    <= out_nxt;
            gnt_id <= gnt_nxt;
            rr_ptr <= rr_ptr_nxt;
            a      <= a_nxt;
            b      <= b_nxt;
            o      <= o_nxt;
        end
    end

    // Unused state encodings fall through to the default and return to IDLE.
    always_comb begin
        state_nxt  = ST_IDLE;
        ack_nxt    = '0;
        out_nxt    = out;
        gnt_nxt    = gnt_id;
        rr_ptr_nxt = rr_ptr;
        a_nxt      = a;
        b_nxt      = b;
        o_nxt      = o;
        case (state)
            ST_IDLE: begin
                if (pick_any) begin
                    a_nxt      = in0[pick_idx];
                    b_nxt      = in1[pick_idx];
                    o_nxt      = op[pick_idx];
                    gnt_nxt    = pick_idx;
                    rr_ptr_nxt = (pick_idx == ID_W'(NUM_REQ-1)) ? '0 : pick_idx + 1'b1;
                    state_nxt  = ST_EVAL;
                end
            end
            ST_EVAL: begin
                out_nxt   = (o == OP_AND) ? ~nand_y : nand_y;
                ack_nxt   = NUM_REQ'(1) << gnt_id;
                state_nxt = ST_ACK;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end
endmodule
